// File: rtl/imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words and writes instruction memory.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        i_clk,
  input  logic        i_srst,
  input  logic        i_byteValid,
  input  logic [7:0]  i_byte,
  output logic        o_byteReady,
  output logic        o_imemWriteEnable,
  output logic [31:0] o_imemWriteAddress,
  output logic [31:0] o_imemWriteData,
  output logic        o_coreHold,
  output logic        o_done,
  output logic        o_error,
  output logic [15:0] o_wordCount
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERROR} state_e;
  localparam state_e S_END = S_CHECK;
`else
  typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERROR} state_e;
  localparam state_e S_END = S_DONE;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [15:0] idx_q, idx_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  acc_q, acc_d;
`endif
  logic        ready;
  logic        accept;

  always_ff @(posedge i_clk) begin
    if (!i_srst) begin
      state_q <= S_LEN0;
      len_q   <= '0;
      word_q  <= '0;
      bcnt_q  <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif

    ready = 1'b0;
    if (i_srst) begin
      case (state_q)
        S_LEN0, S_LEN1, S_DATA: ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK:                ready = 1'b1;
`endif
        default:                ready = 1'b0;
      endcase
    end
    accept = i_byteValid && ready;

    if (accept) begin
      case (state_q)
        S_LEN0: begin
          len_d   = {8'h00, i_byte};
          state_d = S_LEN1;
        end
        S_LEN1: begin
          len_d[15:8] = i_byte;
          if ({16'd0, len_d} > DEPTH_WORDS) state_d = S_ERROR;
          else if (len_d == 16'd0)         state_d = S_END;
          else                             state_d = S_DATA;
        end
        S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          acc_d = acc_q ^ i_byte;
`endif
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            addr_d = {14'd0, idx_q, 2'b00};
            data_d = {i_byte, word_q};
            idx_d  = idx_q + 16'd1;
            bcnt_d = 2'd0;
            if (idx_d == len_q) state_d = S_END;
          end else begin
            case (bcnt_q)
              2'd0:    word_d[7:0]   = i_byte;
              2'd1:    word_d[15:8]  = i_byte;
              default: word_d[23:16] = i_byte;
            endcase
            bcnt_d = bcnt_q + 2'd1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: state_d = (i_byte == acc_q) ? S_DONE : S_ERROR;
`endif
        default: ;
      endcase
    end
  end

  // DONE is entered together with the final strobe; done is withheld until the strobe has retired.
  assign o_done             = (state_q == S_DONE) && !we_q;
  assign o_error            = (state_q == S_ERROR);
  assign o_coreHold         = !o_done;
  assign o_byteReady        = ready;
  assign o_imemWriteEnable  = we_q;
  assign o_imemWriteAddress = addr_q;
  assign o_imemWriteData    = data_q;
  assign o_wordCount        = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum scenarios compiled with IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
  logic        clk;
  logic        srst;
  logic        bvalid;
  logic [7:0]  bdata;
  logic        bready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        hold;
  logic        done;
  logic        err;
  logic [15:0] wcnt;

  int checks;
  int failures;
  logic [63:0] wq[$];

  imem_loader #(.DEPTH_WORDS(64)) dut (
    .i_clk              (clk),
    .i_srst             (srst),
    .i_byteValid        (bvalid),
    .i_byte             (bdata),
    .o_byteReady        (bready),
    .o_imemWriteEnable  (we),
    .o_imemWriteAddress (waddr),
    .o_imemWriteData    (wdata),
    .o_coreHold         (hold),
    .o_done             (done),
    .o_error            (err),
    .o_wordCount        (wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (we) wq.push_back({waddr, wdata});

  task automatic do_reset();
    @(posedge clk); #1;
    srst = 1'b0; bvalid = 1'b0; bdata = 8'h00;
    @(posedge clk); #1;
    srst = 1'b1;
    wq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bvalid = 1'b1; bdata = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    bvalid = 1'b0; bdata = 8'hA5;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%h ready never asserted", b);
    end
  endtask

  task automatic test_load2();
    logic [7:0] s[10];
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    foreach (s[i]) send_byte(s[i]);
    @(negedge clk);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL load2_last_strobe got=%b exp=1", we); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL load2_done_early got=%b exp=0", done); end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2A);
`endif
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL load2_done got=%b exp=1", done); end
    checks++; if (hold !== 1'b0) begin failures++; $display("FAIL load2_hold got=%b exp=0", hold); end
    checks++; if (bready !== 1'b0) begin failures++; $display("FAIL load2_ready got=%b exp=0", bready); end
    checks++; if (wcnt !== 16'd2) begin failures++; $display("FAIL load2_wcnt got=%0d exp=2", wcnt); end
    checks++; if (wq.size() !== 2) begin failures++; $display("FAIL load2_nwrites got=%0d exp=2", wq.size()); end
    else begin
      checks++; if (wq[0] !== {32'h0, 32'h12345678}) begin failures++; $display("FAIL load2_w0 got=%h exp=%h", wq[0], {32'h0, 32'h12345678}); end
      checks++; if (wq[1] !== {32'h4, 32'hDEADBEEF}) begin failures++; $display("FAIL load2_w1 got=%h exp=%h", wq[1], {32'h4, 32'hDEADBEEF}); end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    srst = 1'b0;
    @(negedge clk);
    checks++; if (bready !== 1'b0) begin failures++; $display("FAIL reset_ready_in_reset got=%b exp=0", bready); end
    @(posedge clk); #1;
    srst = 1'b1;
    @(negedge clk);
    checks++; if (bready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", bready); end
    checks++; if ({we, waddr, wdata} !== 65'd0) begin failures++; $display("FAIL reset_wport got=%b/%h/%h exp=0/0/0", we, waddr, wdata); end
    checks++; if ({hold, done, err} !== 3'b100) begin failures++; $display("FAIL reset_flags got=%b exp=100", {hold, done, err}); end
    checks++; if (wcnt !== 16'd0) begin failures++; $display("FAIL reset_wcnt got=%0d exp=0", wcnt); end
  endtask

  task automatic test_throttled();
    logic [7:0] s[10];
    s = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    foreach (s[i]) begin
      send_byte(s[i]);
      bdata = 8'hFF;
      @(posedge clk); #1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h2A);
`endif
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL thr_done got=%b exp=1", done); end
    checks++; if (wcnt !== 16'd2) begin failures++; $display("FAIL thr_wcnt got=%0d exp=2", wcnt); end
    checks++; if (wq.size() !== 2) begin failures++; $display("FAIL thr_nwrites got=%0d exp=2", wq.size()); end
    else begin
      checks++; if (wq[0] !== {32'h0, 32'h12345678}) begin failures++; $display("FAIL thr_w0 got=%h exp=%h", wq[0], {32'h0, 32'h12345678}); end
      checks++; if (wq[1] !== {32'h4, 32'hDEADBEEF}) begin failures++; $display("FAIL thr_w1 got=%h exp=%h", wq[1], {32'h4, 32'hDEADBEEF}); end
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send_byte(8'h41);
    send_byte(8'h00);
    @(negedge clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL over_error got=%b exp=1", err); end
    checks++; if (bready !== 1'b0) begin failures++; $display("FAIL over_ready got=%b exp=0", bready); end
    checks++; if (hold !== 1'b1) begin failures++; $display("FAIL over_hold got=%b exp=1", hold); end
    bvalid = 1'b1; bdata = 8'h11;
    repeat (4) @(negedge clk);
    bvalid = 1'b0;
    checks++; if ({err, done} !== 2'b10) begin failures++; $display("FAIL over_sticky got=%b exp=10", {err, done}); end
    checks++; if (wq.size() !== 0) begin failures++; $display("FAIL over_nwrites got=%0d exp=0", wq.size()); end
  endtask

  task automatic test_boundary_len();
    do_reset();
    send_byte(8'h40);
    send_byte(8'h00);
    @(negedge clk);
    checks++; if ({err, bready} !== 2'b01) begin failures++; $display("FAIL len64_accepted got=%b exp=01", {err, bready}); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] s[6];
    s = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    do_reset();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h78); send_byte(8'h56);
    do_reset();
    foreach (s[i]) send_byte(s[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h44);
`endif
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b exp=1", done); end
    checks++; if (wcnt !== 16'd1) begin failures++; $display("FAIL rmid_wcnt got=%0d exp=1", wcnt); end
    checks++; if (wq.size() !== 1) begin failures++; $display("FAIL rmid_nwrites got=%0d exp=1", wq.size()); end
    else begin
      checks++; if (wq[0] !== {32'h0, 32'h11223344}) begin failures++; $display("FAIL rmid_w0 got=%h exp=%h", wq[0], {32'h0, 32'h11223344}); end
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    checks++; if ({done, bready} !== 2'b01) begin failures++; $display("FAIL zero_wait_trailer got=%b exp=01", {done, bready}); end
    send_byte(8'h00);
`endif
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
    checks++; if (hold !== 1'b0) begin failures++; $display("FAIL zero_hold got=%b exp=0", hold); end
    checks++; if (wq.size() !== 0) begin failures++; $display("FAIL zero_nwrites got=%0d exp=0", wq.size()); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] tr[2];
    tr = '{8'h0F, 8'h0E};
    for (int k = 0; k < 2; k++) begin
      do_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
      send_byte(tr[k]);
      @(negedge clk);
      checks++; if (wq.size() !== 1 || wq[0] !== {32'h0, 32'h08040201}) begin
        failures++; $display("FAIL ck_write case=%0d n=%0d exp one write 0/08040201", k, wq.size());
      end
      checks++; if ({done, err, hold} !== ((k == 0) ? 3'b100 : 3'b011)) begin
        failures++; $display("FAIL ck_result case=%0d got=%b exp=%b", k, {done, err, hold}, (k == 0) ? 3'b100 : 3'b011);
      end
    end
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    srst = 1'b0; bvalid = 1'b0; bdata = 8'h00;
    repeat (2) @(posedge clk);
    test_load2();
    test_reset();
    test_throttled();
    test_oversize();
    test_boundary_len();
    test_reset_mid_word();
    test_zero_len();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory the single-cycle core reads. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives the instruction-memory write port. Holds the core in reset until a complete image is stored. Sits between the host byte source (UART receiver or bench) and the instruction memory, beside the core top.

## Interface

Parameters:
- DEPTH_WORDS, 64: instruction-memory capacity in 32-bit words; images longer than this are rejected.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_srst  input  1  synchronous reset, active-low (0 = reset).
- i_byteValid  input  1  source presents a byte.
- i_byte  input  8  stream byte.
- o_byteReady  output  1  loader accepts a byte this cycle.
- o_imemWriteEnable  output  1  one-cycle write strobe to instruction memory.
- o_imemWriteAddress  output  32  byte address, always a multiple of 4.
- o_imemWriteData  output  32  assembled word.
- o_coreHold  output  1  high keeps the core in reset; low once the image is loaded.
- o_done  output  1  image loaded successfully; sticky.
- o_error  output  1  image rejected; sticky.
- o_wordCount  output  16  words written so far.

## Operation

- Byte transfer occurs only when i_byteValid && o_byteReady in the same cycle; i_byte ignored otherwise.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes, each word LSB first. With the checksum macro, one trailing checksum byte follows.
- States: LEN0 -> LEN1 -> DATA -> (CHECK) -> DONE; ERROR reachable from LEN1 and CHECK.
  - LEN0: accept LEN_LO -> LEN1.
  - LEN1: accept LEN_HI. If N > DEPTH_WORDS -> ERROR. If N == 0 -> DONE (or CHECK when the checksum is compiled in). Otherwise -> DATA.
  - DATA: shift bytes into the word register, byte k into bits [8k+7:8k]. On the 4th byte, issue the write, clear the byte counter and increment the word index. After word N-1 -> DONE (or CHECK).
  - CHECK: accept one byte and compare -> DONE on match, ERROR on mismatch.
  - DONE / ERROR: terminal until reset. o_byteReady = 0.
- o_byteReady = 1 in LEN0, LEN1, DATA and CHECK; 0 in DONE and ERROR.
- Write address = word index * 4, starting at 0. Word index is 16 bits wide and never exceeds DEPTH_WORDS, so it cannot wrap.
- o_coreHold = 1 in every state except DONE. ERROR keeps the core held.

## Timing

- Reset (i_srst = 0 at a rising edge): state = LEN0, o_byteReady = 0 during reset, o_imemWriteEnable = 0, o_imemWriteAddress = 0, o_imemWriteData = 0, o_coreHold = 1, o_done = 0, o_error = 0, o_wordCount = 0, checksum accumulator = 0. A partial word is discarded.
- The first cycle after reset is released has o_byteReady = 1.
- Write latency: 4th byte accepted at cycle t -> o_imemWriteEnable = 1 for exactly cycle t+1, with address and data valid in that same cycle. o_wordCount increments at t+1.
- Without checksum: the final word's 4th byte is accepted at t, the write strobe is at t+1, and o_done = 1 and o_coreHold = 0 from t+2.
- N == 0 without checksum: LEN_HI accepted at t -> o_done = 1 from t+1. No write occurs.
- ERROR after LEN_HI at t: o_error = 1 from t+1. No write ever occurs.
- Back-to-back bytes are accepted at full rate, one per cycle. Gaps in i_byteValid stall without losing state.
- Reset asserted mid-image (any state) takes priority at that edge and fully restarts the load. Memory contents already written are not cleared.

## Configuration

- IMEM_LOADER_CHECKSUM_EN defined: the accumulator XORs every payload byte; LEN bytes are excluded.
  - The CHECK state expects one trailing byte equal to the accumulator. The final word's write strobe at t+1 still occurs.
  - The checksum byte accepted at cycle c -> o_done or o_error from c+1.
  - N == 0 requires a trailing byte of 0x00.
- Macro undefined: no CHECK state and no accumulator. o_error is raised only by an oversize N.

## Test plan

- Load N=2: stream 02 00 78 56 34 12 EF BE AD DE -> writes (0x0, 0x12345678) and (0x4, 0xDEADBEEF), each a single-cycle strobe. o_wordCount = 2, o_done = 1, o_coreHold = 0.
- Throttled source: same image with i_byteValid toggling every other cycle -> identical writes and values. No byte is duplicated or dropped.
- Oversize: DEPTH_WORDS = 64, header 41 00 (N = 65) -> o_error = 1 the cycle after LEN_HI. No write strobe, o_byteReady = 0, o_coreHold = 1.
- Reset mid-word: after 02 00 78 56, drive i_srst = 0 for one cycle, then send a full N=1 image 01 00 44 33 22 11 -> single write (0x0, 0x11223344). o_wordCount = 1.
- N=0: header 00 00 -> o_done = 1 with no write strobe. With IMEM_LOADER_CHECKSUM_EN, o_done follows a trailing 00.
- Checksum (IMEM_LOADER_CHECKSUM_EN): N=1, payload 01 02 04 08, trailer 0F -> o_done = 1. The same stream with trailer 0E -> write still occurs, then o_error = 1 and o_coreHold = 1.
